// File: rtl/ysyx_220066_lsu.sv
// ysyx_220066_lsu: load/store unit between the M stage and a valid/ready data bus
// Ports: clk, rst (async active-low); core side MemRd/MemWr/MemOp/addr/data_Wr in,
//        data_Rd/data_Rd_valid/data_Rd_error/busy out; bus side req_* out with
//        req_ready in, resp_valid/resp_rdata/resp_error in.
// Optional: define LSU_TIMEOUT_EN to abort REQ/WAIT after TIMEOUT cycles with an error.
module ysyx_220066_lsu #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRd,
    input  logic        MemWr,
    input  logic [2:0]  MemOp,
    input  logic [63:0] addr,
    input  logic [63:0] data_Wr,
    output logic [63:0] data_Rd,
    output logic        data_Rd_valid,
    output logic        data_Rd_error,
    output logic        busy,
    output logic        req_valid,
    input  logic        req_ready,
    output logic        req_wen,
    output logic [63:0] req_addr,
    output logic [63:0] req_wdata,
    output logic [7:0]  req_wmask,
    input  logic        resp_valid,
    input  logic [63:0] resp_rdata,
    input  logic        resp_error
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    state_t state_q, state_d;
    logic [2:0]  op_q, op_d, off_q, off_d;
    logic        wen_q, wen_d, err_q, err_d;
    logic [63:0] addr_q, addr_d, wdata_q, wdata_d, data_q, data_d;
    logic [7:0]  wmask_q, wmask_d;
    logic [2:0]  a;
    logic [1:0]  sz;
    logic        misal, bad, expired;
    logic [7:0]  mask_n;
    logic [63:0] sh, ext;
    assign a = addr[2:0];
    assign sz = MemOp[1:0];
    assign misal = (sz == 2'd1 && a[0]) || (sz == 2'd2 && |a[1:0]) || (sz == 2'd3 && |a);
    assign bad = (MemRd && MemWr) || (MemRd && MemOp == 3'b111) || misal;
    assign mask_n = !MemWr ? 8'hFF : sz == 2'd0 ? 8'h01 << a : sz == 2'd1 ? 8'h03 << a :
                    sz == 2'd2 ? 8'h0F << a : 8'hFF;
    assign sh = resp_rdata >> {off_q, 3'b000};
    assign ext = op_q == 3'b000 ? {{56{sh[7]}}, sh[7:0]} :
                 op_q == 3'b001 ? {{48{sh[15]}}, sh[15:0]} :
                 op_q == 3'b010 ? {{32{sh[31]}}, sh[31:0]} :
                 op_q == 3'b011 ? sh :
                 op_q == 3'b100 ? {56'd0, sh[7:0]} :
                 op_q == 3'b101 ? {48'd0, sh[15:0]} : {32'd0, sh[31:0]};
`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    // Restarts on every state change, so REQ and WAIT each get a full budget.
    assign cnt_d = (state_d == state_q && (state_q == REQ || state_q == WAIT)) ? cnt_q + 1'b1 : '0;
    assign expired = cnt_q == CW'(TIMEOUT - 1);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
`else
    assign expired = TIMEOUT < 0;
`endif
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        off_d   = off_q;
        wen_d   = wen_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (MemRd || MemWr) begin
                op_d    = MemOp;
                off_d   = a;
                wen_d   = MemWr;
                addr_d  = {addr[63:3], 3'b000};
                wdata_d = data_Wr << {a, 3'b000};
                wmask_d = mask_n;
                data_d  = '0;
                err_d   = bad;
                state_d = bad ? DONE : REQ;
            end
            REQ: begin
                state_d = req_ready ? WAIT : expired ? DONE : REQ;
                err_d   = !req_ready && expired;
            end
            WAIT: if (resp_valid) begin
                state_d = DONE;
                err_d   = resp_error;
                data_d  = (resp_error || wen_q) ? '0 : ext;
            end else if (expired) begin
                state_d = DONE;
                err_d   = 1'b1;
            end
            default: begin
                state_d = IDLE;
                err_d   = 1'b0;
                data_d  = '0;
            end
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            off_q   <= '0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            off_q   <= off_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end
    assign data_Rd       = data_q;
    assign data_Rd_valid = state_q == DONE;
    assign data_Rd_error = err_q;
    assign busy          = state_q == REQ || state_q == WAIT;
    assign req_valid     = state_q == REQ;
    assign req_wen       = wen_q;
    assign req_addr      = addr_q;
    assign req_wdata     = wdata_q;
    assign req_wmask     = wmask_q;
endmodule

// File: tb/tb_ysyx_220066_lsu.sv
// tb_ysyx_220066_lsu: vector table, random transactions against a reference model, reset and timeout sequences
module tb_ysyx_220066_lsu;
    logic clk = 0, rst = 0;
    logic MemRd = 0, MemWr = 0;
    logic [2:0] MemOp = 0;
    logic [63:0] addr = 0, data_Wr = 0;
    logic [63:0] data_Rd, req_addr, req_wdata;
    logic data_Rd_valid, data_Rd_error, busy, req_valid, req_wen;
    logic [7:0] req_wmask;
    logic req_ready = 0, resp_valid = 0, resp_error = 0;
    logic [63:0] resp_rdata = 0;
    always #5 clk = ~clk;
    ysyx_220066_lsu #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .MemRd(MemRd), .MemWr(MemWr), .MemOp(MemOp),
        .addr(addr), .data_Wr(data_Wr), .data_Rd(data_Rd), .data_Rd_valid(data_Rd_valid),
        .data_Rd_error(data_Rd_error), .busy(busy), .req_valid(req_valid),
        .req_ready(req_ready), .req_wen(req_wen), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wmask(req_wmask), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_error(resp_error)
    );
    typedef struct {
        logic rd, wr; logic [2:0] op; logic [63:0] addr, wdata, rdata; logic rerr;
        int rs, ps; logic [63:0] e_data; logic e_err; int e_lat; logic e_req;
        logic [63:0] e_raddr; logic [7:0] e_mask; logic [63:0] e_wdata;
    } vec_t;
    int n_chk = 0, n_err = 0;
    int o_lat;
    logic [63:0] o_data, o_raddr, o_wdata;
    logic [7:0] o_mask;
    logic o_err, o_req, o_wen, o_stable, o_busy_ok;
    vec_t tv[12];
    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask
    function automatic vec_t model(input vec_t v);
        int bytes, a;
        logic bad;
        logic [63:0] x, m;
        bytes = 1 << v.op[1:0];
        a = int'(v.addr[2:0]);
        bad = (v.rd && v.wr) || (v.rd && v.op == 3'b111) || (a % bytes != 0);
        v.e_req = !bad;
        v.e_lat = bad ? 1 : 3 + v.rs + v.ps;
        v.e_err = bad || v.rerr;
        v.e_raddr = v.addr & ~64'h7;
        v.e_mask = v.wr ? 8'(((1 << bytes) - 1) << a) : 8'hFF;
        v.e_wdata = v.wdata << (8 * a);
        x = v.rdata >> (8 * a);
        if (bytes < 8) begin
            m = (64'd1 << (8 * bytes)) - 1;
            x = x & m;
            if (!v.op[2] && x[8 * bytes - 1]) x = x | ~m;
        end
        v.e_data = (bad || v.rerr || v.wr) ? 64'd0 : x;
        return v;
    endfunction
    task automatic run(input vec_t v);
        bit acc;
        int rq, rc;
        acc = 0; rq = 0; rc = 0;
        o_lat = -1; o_req = 0; o_stable = 1; o_busy_ok = 1; o_data = 'x; o_err = 'x;
        @(negedge clk);
        MemRd = v.rd; MemWr = v.wr; MemOp = v.op; addr = v.addr; data_Wr = v.wdata;
        @(negedge clk);
        MemRd = 0; MemWr = 0; MemOp = 3'($urandom); addr = {$urandom, $urandom}; data_Wr = {$urandom, $urandom};
        for (int i = 1; i < 100; i++) begin
            if (data_Rd_valid) begin
                o_lat = i; o_data = data_Rd; o_err = data_Rd_error;
                if (busy) o_busy_ok = 0;
                break;
            end
            if (req_valid) begin
                if (!busy) o_busy_ok = 0;
                if (!o_req) begin
                    o_req = 1; o_raddr = req_addr; o_mask = req_wmask; o_wdata = req_wdata; o_wen = req_wen;
                end else if ({req_addr, req_wmask, req_wdata, req_wen} !== {o_raddr, o_mask, o_wdata, o_wen}) o_stable = 0;
                req_ready = rq >= v.rs;
                if (req_ready) acc = 1;
                else rq++;
            end else if (acc) begin
                req_ready = 1'($urandom);
                resp_valid = rc >= v.ps;
                resp_rdata = resp_valid ? v.rdata : {$urandom, $urandom};
                resp_error = resp_valid ? v.rerr : 1'($urandom);
                rc++;
            end
            @(negedge clk);
        end
        req_ready = 0; resp_valid = 0; resp_error = 0;
    endtask
    task automatic check(input vec_t v, input string t);
        chk({t, " lat"}, 64'(o_lat), 64'(v.e_lat));
        chk({t, " err"}, 64'(o_err), 64'(v.e_err));
        chk({t, " data"}, o_data, v.e_data);
        chk({t, " req_seen"}, 64'(o_req), 64'(v.e_req));
        chk({t, " busy"}, 64'(o_busy_ok), 64'd1);
        if (v.e_req) begin
            chk({t, " raddr"}, o_raddr, v.e_raddr);
            chk({t, " mask"}, 64'(o_mask), 64'(v.e_mask));
            chk({t, " wen"}, 64'(o_wen), 64'(v.wr));
            chk({t, " stable"}, 64'(o_stable), 64'd1);
            if (v.wr) chk({t, " wdata"}, o_wdata, v.e_wdata);
        end
    endtask
    initial begin
        vec_t v;
        logic seen;
        tv[0]  = '{1, 0, 3'b000, 64'h80000003, 64'h0, 64'h00000000_F0000000, 0, 0, 0, 64'hFFFFFFFF_FFFFFFF0, 0, 3, 1, 64'h80000000, 8'hFF, 64'h0};
        tv[1]  = '{0, 1, 3'b001, 64'h80000006, 64'h1234, 64'h0, 0, 0, 0, 64'h0, 0, 3, 1, 64'h80000000, 8'hC0, 64'h1234_0000_0000_0000};
        tv[2]  = '{1, 0, 3'b010, 64'h80000002, 64'h0, 64'h0, 0, 0, 0, 64'h0, 1, 1, 0, 64'h0, 8'h0, 64'h0};
        tv[3]  = '{1, 0, 3'b110, 64'h80000004, 64'h0, 64'hDEADBEEF_00000000, 0, 5, 0, 64'h00000000_DEADBEEF, 0, 8, 1, 64'h80000000, 8'hFF, 64'h0};
        tv[4]  = '{1, 0, 3'b011, 64'h80000010, 64'h0, 64'h1111_2222_3333_4444, 1, 0, 0, 64'h0, 1, 3, 1, 64'h80000010, 8'hFF, 64'h0};
        tv[5]  = '{1, 0, 3'b001, 64'h1002, 64'h0, 64'h0000_0000_8001_0000, 0, 0, 2, 64'hFFFFFFFF_FFFF8001, 0, 5, 1, 64'h1000, 8'hFF, 64'h0};
        tv[6]  = '{0, 1, 3'b011, 64'h4, 64'hFF, 64'h0, 0, 0, 0, 64'h0, 1, 1, 0, 64'h0, 8'h0, 64'h0};
        tv[7]  = '{1, 1, 3'b000, 64'h8, 64'h0, 64'h0, 0, 0, 0, 64'h0, 1, 1, 0, 64'h0, 8'h0, 64'h0};
        tv[8]  = '{1, 0, 3'b111, 64'h10, 64'h0, 64'h0, 0, 0, 0, 64'h0, 1, 1, 0, 64'h0, 8'h0, 64'h0};
        tv[9]  = '{0, 1, 3'b000, 64'h7, 64'hAB, 64'h0, 0, 1, 1, 64'h0, 0, 5, 1, 64'h0, 8'h80, 64'hAB00_0000_0000_0000};
        tv[10] = '{0, 1, 3'b111, 64'h8, 64'h01234567_89ABCDEF, 64'h0, 1, 0, 0, 64'h0, 1, 3, 1, 64'h8, 8'hFF, 64'h01234567_89ABCDEF};
        tv[11] = '{1, 0, 3'b100, 64'h21, 64'h0, 64'h8000, 0, 0, 0, 64'h80, 0, 3, 1, 64'h20, 8'hFF, 64'h0};
        repeat (3) @(negedge clk);
        chk("reset ctl", 64'({req_valid, busy, data_Rd_valid, data_Rd_error, req_wen, req_wmask}), 64'd0);
        chk("reset data", data_Rd | req_addr | req_wdata, 64'd0);
        rst = 1;
        for (int i = 0; i < 12; i++) begin
            run(tv[i]);
            check(tv[i], $sformatf("vec%0d", i));
        end
        for (int i = 0; i < 60; i++) begin
            int r;
            r = $urandom_range(0, 9);
            v.rd = r < 5 || r == 9; v.wr = r >= 5;
            v.op = 3'($urandom);
            v.addr = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) v.addr = v.addr & ~64'((1 << v.op[1:0]) - 1);
            v.wdata = {$urandom, $urandom}; v.rdata = {$urandom, $urandom};
            v.rerr = $urandom_range(0, 7) == 0;
            v.rs = $urandom_range(0, 3); v.ps = $urandom_range(0, 3);
            v = model(v);
            run(v);
            check(v, $sformatf("rnd%0d", i));
        end
        @(negedge clk);
        MemRd = 1; MemOp = 3'b011; addr = 64'h200;
        @(negedge clk);
        MemRd = 0;
        chk("mid req_valid", 64'(req_valid), 64'd1);
        req_ready = 1;
        @(negedge clk);
        req_ready = 0;
        chk("mid wait", 64'({busy, req_valid}), 64'b10);
        rst = 0;
        #1;
        chk("mid reset ctl", 64'({req_valid, busy, data_Rd_valid, data_Rd_error, req_wen, req_wmask}), 64'd0);
        chk("mid reset data", data_Rd | req_addr | req_wdata, 64'd0);
        @(negedge clk);
        rst = 1; resp_valid = 1; resp_rdata = 64'h55AA;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | data_Rd_valid | req_valid | busy;
        end
        resp_valid = 0;
        chk("late resp ignored", 64'(seen), 64'd0);
`ifdef LSU_TIMEOUT_EN
        v = '{1, 0, 3'b011, 64'h40, 64'h0, 64'h0, 0, 0, 1000, 64'h0, 1, 10, 1, 64'h40, 8'hFF, 64'h0};
        run(v);
        check(v, "timeout");
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
